// File: rtl/sr_latch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_arbiter
// Brief    : Round-robin sharing of one gated SR latch, driven through a
//            setup/pulse/hold sequence. Optional Q readback check is built
//            when SR_LATCH_ARB_READBACK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module sr_latch_arbiter #(
    parameter int N_REQ     = 4,
    parameter int PULSE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] cmd_s,
    input  logic [N_REQ-1:0] cmd_r,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] nack,
    output logic             busy,
    output logic             latch_en,
    output logic             latch_s,
    output logic             latch_r,
    input  logic             latch_q,
    output logic             err
);

    localparam int c_ptr_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_cnt_w = $clog2(PULSE_CYC + 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_setup = 2'd1;
    localparam logic [1:0] c_st_pulse = 2'd2;
    localparam logic [1:0] c_st_hold  = 2'd3;

    localparam logic [c_ptr_w:0]   c_n_req   = (c_ptr_w + 1)'(N_REQ);
    localparam logic [c_ptr_w-1:0] c_last    = c_ptr_w'(N_REQ - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_ld  = c_cnt_w'(PULSE_CYC - 1);
    localparam logic [N_REQ-1:0]   c_one_hot = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w-1:0] r_idx;
    logic [c_cnt_w-1:0] r_cnt;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_nack;
    logic               r_busy;
    logic               r_latch_en;
    logic               r_latch_s;
    logic               r_latch_r;

    logic               w_found;
    logic [c_ptr_w-1:0] w_win;
    logic [c_ptr_w:0]   w_sum;
    logic               w_legal;
    logic [c_ptr_w-1:0] w_ptr_next;

    // Rotating search starting at r_ptr; first requester found wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (c_ptr_w + 1)'(i);
            if (w_sum >= c_n_req) begin
                w_sum = w_sum - c_n_req;
            end
            if (!w_found && req[w_sum[c_ptr_w-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[c_ptr_w-1:0];
            end
        end
    end

    assign w_legal    = cmd_s[w_win] ^ cmd_r[w_win];
    assign w_ptr_next = (w_win == c_last) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_nack     <= '0;
            r_busy     <= 1'b0;
            r_latch_en <= 1'b0;
            r_latch_s  <= 1'b0;
            r_latch_r  <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_nack <= '0;
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_ptr <= w_ptr_next;
                        if (w_legal) begin
                            r_state   <= c_st_setup;
                            r_idx     <= w_win;
                            r_busy    <= 1'b1;
                            r_latch_s <= cmd_s[w_win];
                            r_latch_r <= cmd_r[w_win];
                        end else begin
                            r_nack <= c_one_hot << w_win;
                        end
                    end
                end
                c_st_setup: begin
                    r_state    <= c_st_pulse;
                    r_latch_en <= 1'b1;
                    r_cnt      <= c_cnt_ld;
                end
                c_st_pulse: begin
                    if (r_cnt == '0) begin
                        r_state    <= c_st_hold;
                        r_latch_en <= 1'b0;
                        r_gnt      <= c_one_hot << r_idx;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_st_hold: begin
                    r_state   <= c_st_idle;
                    r_busy    <= 1'b0;
                    r_latch_s <= 1'b0;
                    r_latch_r <= 1'b0;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign nack     = r_nack;
    assign busy     = r_busy;
    assign latch_en = r_latch_en;
    assign latch_s  = r_latch_s;
    assign latch_r  = r_latch_r;

`ifdef SR_LATCH_ARB_READBACK_EN
    logic r_err;

    // Q is sampled on the edge that enters HOLD so the flag is visible in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == c_st_pulse && r_cnt == '0 && latch_q != r_latch_s) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_q;
    assign w_unused_q = latch_q;
    assign err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_latch_arbiter
// Brief    : Self-checking bench for sr_latch_arbiter with a transaction-level
//            reference model and a behavioural gated SR latch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_latch_arbiter;

    localparam int N  = 4;
    localparam int PC = 2;
`ifdef SR_LATCH_ARB_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req, cmd_s, cmd_r, gnt, nack;
    logic         busy, latch_en, latch_s, latch_r, latch_q, err;

    logic lq      = 1'b0;
    logic stub_q0 = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   m_ptr   = 0;
    logic m_err   = 1'b0;

    sr_latch_arbiter #(.N_REQ(N), .PULSE_CYC(PC)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd_s(cmd_s), .cmd_r(cmd_r),
        .gnt(gnt), .nack(nack), .busy(busy), .latch_en(latch_en),
        .latch_s(latch_s), .latch_r(latch_r), .latch_q(latch_q), .err(err)
    );

    always #5 clk = ~clk;

    // Gated SR latch: transparent while EN is high; stub can force Q low.
    always @(latch_en or latch_s or latch_r) begin
        if (latch_en && latch_s) lq = 1'b1;
        else if (latch_en && latch_r) lq = 1'b0;
    end
    assign latch_q = stub_q0 ? 1'b0 : lq;

    function automatic logic [31:0] pack(input logic [N-1:0] g, input logic [N-1:0] nk,
                                         input logic b, input logic en, input logic s,
                                         input logic r, input logic e);
        return 32'({g, nk, b, en, s, r, e});
    endfunction

    function automatic logic [31:0] obs();
        return 32'({gnt, nack, busy, latch_en, latch_s, latch_r, err});
    endfunction

    function automatic int model_winner(input logic [N-1:0] rq, input int p);
        for (int k = 0; k < N; k++) begin
            if (rq[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            req   = N'($urandom);
            cmd_s = N'($urandom);
            cmd_r = N'($urandom);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s c%0d", tag, c), obs(), pack('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        rst   = 1'b0;
        req   = '0;
        m_ptr = 0;
        m_err = 1'b0;
    endtask

    // One request pattern presented in IDLE, followed to completion.
    task automatic do_txn(input string tag, input logic [N-1:0] rq, input logic [N-1:0] cs,
                          input logic [N-1:0] cr, input bit hold);
        int           w;
        logic         set;
        logic [N-1:0] oh;
        req   = rq;
        cmd_s = cs;
        cmd_r = cr;
        w     = model_winner(rq, m_ptr);
        @(posedge clk);
        if (w < 0) begin
            @(negedge clk);
            check({tag, " none"}, obs(), pack('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, m_err));
            return;
        end
        oh    = N'(1) << w;
        m_ptr = (w + 1) % N;
        if (cs[w] == cr[w]) begin
            @(negedge clk);
            check({tag, " nack"}, obs(), pack('0, oh, 1'b0, 1'b0, 1'b0, 1'b0, m_err));
            if (!hold) req = '0;
            return;
        end
        set = cs[w];
        for (int k = 1; k <= PC + 2; k++) begin
            @(negedge clk);
            if (RB && k == PC + 2 && stub_q0 && set) m_err = 1'b1;
            check($sformatf("%s k%0d", tag, k), obs(),
                  pack((k == PC + 2) ? oh : '0, '0, 1'b1, (k >= 2 && k <= PC + 1),
                       set, !set, m_err));
            if (k == 2 && !hold) begin
                req   = '0;
                cmd_s = N'($urandom);
                cmd_r = N'($urandom);
            end
            @(posedge clk);
        end
        @(negedge clk);
        check({tag, " done"}, obs(), pack('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, m_err));
        if (!stub_q0) check({tag, " q"}, 32'(latch_q), 32'(set));
    endtask

    initial begin
        req   = '0;
        cmd_s = '0;
        cmd_r = '0;
        @(negedge clk);
        do_reset("reset");

        do_txn("lowest_set", 4'b0110, 4'b0110, 4'b0000, 1'b0);
        do_txn("reset_op", 4'b0010, 4'b0000, 4'b0010, 1'b0);

        do_reset("rr_rst");
        for (int g = 0; g < 5; g++) do_txn($sformatf("rr%0d", g), 4'hF, 4'h5, 4'hA, 1'b1);
        do_txn("rr_1001", 4'b1001, 4'b1001, 4'b0000, 1'b0);

        do_txn("ill_11", 4'b0100, 4'b0100, 4'b0100, 1'b0);
        do_txn("ill_00", 4'b0100, 4'b0000, 4'b0000, 1'b0);
        do_txn("after_ill", 4'b0101, 4'b0100, 4'b0001, 1'b0);
        do_txn("midop", 4'b0001, 4'b0001, 4'b0000, 1'b0);
        do_txn("no_req", 4'b0000, 4'hF, 4'h0, 1'b0);

        // Reset arriving in the first PULSE cycle aborts the operation.
        req   = 4'b0001;
        cmd_s = 4'b0000;
        cmd_r = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid pulse", obs(), pack('0, '0, 1'b1, 1'b1, 1'b0, 1'b1, m_err));
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid abort", obs(), pack('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst   = 1'b0;
        m_ptr = 0;
        m_err = 1'b0;
        for (int c = 0; c < PC + 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rst_mid quiet%0d", c), obs(), pack('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end

        for (int t = 0; t < 24; t++) begin
            do_txn($sformatf("rnd%0d", t), N'($urandom), N'($urandom), N'($urandom), 1'b0);
        end

`ifdef SR_LATCH_ARB_READBACK_EN
        do_reset("rb_rst");
        stub_q0 = 1'b1;
        do_txn("rb_set", 4'b0001, 4'b0001, 4'b0000, 1'b0);
        stub_q0 = 1'b0;
        do_txn("rb_sticky", 4'b0010, 4'b0000, 4'b0010, 1'b0);
        do_reset("rb_clear");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
